// File: rtl/ex_muldiv_pkg.sv
// Shared opcode/func3 encodings, FSM states and helpers for the EX-stage M-extension unit.
package ex_muldiv_pkg;

  localparam logic [6:0] EXE_OP_M    = 7'b0110011;
  localparam logic [6:0] EXE_FUNC7_M = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div_core.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
module div_core
  import ex_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        step_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        done_o
);

  logic [31:0] rem_q, quo_q, dvs_q;
  logic [4:0]  cnt_q;
  logic [32:0] shifted, trial;
  logic [31:0] rem_d, quo_d;
  logic [31:0] dvd_mag, dvs_mag;

  assign dvd_mag = (signed_i && dividend_i[31]) ? neg32(dividend_i) : dividend_i;
  assign dvs_mag = (signed_i && divisor_i[31])  ? neg32(divisor_i)  : divisor_i;

  // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dvs_q};
    rem_d   = trial[32] ? shifted[31:0] : trial[31:0];
    quo_d   = {quo_q[30:0], ~trial[32]};
  end

  // Post-step values, so the caller can register the final result on the last step.
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;
  assign done_o      = step_i && (cnt_q == 5'(DIV_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      rem_q <= '0;
      quo_q <= dvd_mag;
      dvs_q <= dvs_mag;
      cnt_q <= '0;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 5'd1;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M unit: single-cycle multiply, 32-step iterative divide, stalls the pipeline meanwhile.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  ex_opcode,
  input  logic [2:0]  ex_func3,
  input  logic [6:0]  ex_func7,
  input  logic [31:0] ex_reg1,
  input  logic [31:0] ex_reg2,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic        hold,
  output logic        stallreq,
  output logic        md_valid,
  output logic [31:0] md_wdata,
  output logic [4:0]  md_wd,
  output logic        md_wreg,
  output md_state_e   dbg_state
);

  // Handshake: stallreq freezes IF/ID/EX while an op is accepted or computing; md_valid
  // marks the single DONE cycle (extended while hold=1) where md_wdata/md_wd/md_wreg are final.
  md_state_e   state_q, state_d;
  logic [31:0] a_q, b_q, wdata_q, wdata_d;
  logic [2:0]  f3_q;
  logic [4:0]  wd_q;
  logic        wreg_q;

  logic        is_m, div_zero, div_ovf, div_start, div_done;
  logic [31:0] div_quo, div_rem, quo_fix, rem_fix;
  logic        a_sgn, b_sgn;
  logic signed [63:0] mul_a, mul_b, mul_p;

  assign is_m      = (ex_opcode == EXE_OP_M) && (ex_func7 == EXE_FUNC7_M);
  assign div_zero  = (ex_reg2 == 32'd0);
  assign div_ovf   = !ex_func3[0] && (ex_reg1 == 32'h8000_0000) && (ex_reg2 == 32'hFFFF_FFFF);
  assign div_start = (state_q == S_IDLE) && is_m && ex_func3[2] && !div_zero && !div_ovf;

  div_core u_div_core (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .step_i      (state_q == S_DIV),
    .signed_i    (!ex_func3[0]),
    .dividend_i  (ex_reg1),
    .divisor_i   (ex_reg2),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .done_o      (div_done)
  );

  // Sign-extend each operand to 64 bits according to the MULH* flavour.
  assign a_sgn = (f3_q != F3_MULHU);
  assign b_sgn = (f3_q == F3_MUL) || (f3_q == F3_MULH);
  assign mul_a = {{32{a_sgn & a_q[31]}}, a_q};
  assign mul_b = {{32{b_sgn & b_q[31]}}, b_q};
  assign mul_p = mul_a * mul_b;

  assign quo_fix = (!f3_q[0] && (a_q[31] ^ b_q[31])) ? neg32(div_quo) : div_quo;
  assign rem_fix = (!f3_q[0] && a_q[31]) ? neg32(div_rem) : div_rem;

  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (is_m) begin
          if (!ex_func3[2]) begin
            state_d = S_MUL;
          end else if (div_zero) begin
            wdata_d = ex_func3[1] ? ex_reg1 : 32'hFFFF_FFFF;
            state_d = S_DONE;
          end else if (div_ovf) begin
            wdata_d = ex_func3[1] ? 32'd0 : 32'h8000_0000;
            state_d = S_DONE;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        wdata_d = (f3_q == F3_MUL) ? mul_p[31:0] : mul_p[63:32];
        state_d = S_DONE;
      end
      S_DIV: begin
        if (div_done) begin
          wdata_d = f3_q[1] ? rem_fix : quo_fix;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wdata_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      if (state_q == S_IDLE && is_m) begin
        a_q    <= ex_reg1;
        b_q    <= ex_reg2;
        f3_q   <= ex_func3;
        wd_q   <= ex_wd;
        wreg_q <= ex_wreg;
      end
    end
  end

  assign stallreq  = !rst && ((state_q == S_IDLE && is_m) || state_q == S_MUL || state_q == S_DIV);
  assign md_valid  = (state_q == S_DONE);
  assign md_wdata  = wdata_q;
  assign md_wd     = wd_q;
  assign md_wreg   = wreg_q;
  assign dbg_state = state_q;

endmodule
